// File: rtl/mem_port_bridge.sv
// mem_port_bridge: registered adapter between the multicycle RV32I datapath/control pair and a
// variable-latency physical memory port. One CPU load/store is captured, issued on pmem, and
// completed with a single-cycle mem_resp pulse. At most one transaction is in flight.
//
// Configuration macro: MEM_BRIDGE_TIMEOUT_EN
//   defined   - ACCESS is abandoned after TIMEOUT_CYCLES cycles without pmem_resp; err_timeout
//               pulses with mem_resp and mem_rdata reads 0.
//   undefined - ACCESS waits indefinitely; err_timeout is tied 0.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   mem_read, mem_write          CPU request strobes, held until mem_resp
//   mem_address, mem_byte_sel    word address ([1:0] ignored) and byte offset
//   mem_size, mem_wdata          access size (00 b, 01 h, 10 w, 11 illegal), right-justified data
//   mem_resp, mem_rdata          completion pulse and raw read word
//   err_misalign, err_timeout    error flags, valid with mem_resp
//   pmem_read, pmem_write        memory strobes, held until pmem_resp
//   pmem_address, pmem_wdata     word-aligned address and lane-aligned store data
//   pmem_mbe                     byte enables
//   pmem_resp, pmem_rdata        memory completion and read data
`timescale 1ns / 1ps

module mem_port_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [1:0]  mem_byte_sel,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_wdata,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        err_misalign,
    output logic        err_timeout,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_mbe,
    input  logic        pmem_resp,
    input  logic [31:0] pmem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e      state_q, state_d;

    logic        req;
    logic        req_misalign;
    logic [3:0]  req_mbe;
    logic [31:0] req_wdata;
    logic        timeout_hit;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  mbe_q;
    logic        is_write_q;
    logic        misalign_q;
    logic [31:0] rdata_q;

    logic        unused_addr_bits;
    assign unused_addr_bits = ^mem_address[1:0];

    assign req       = mem_read | mem_write;
    assign req_wdata = mem_wdata << {mem_byte_sel, 3'b000};

    // Byte enables and alignment check for the incoming request.
    always_comb begin
        req_mbe      = 4'b0000;
        req_misalign = 1'b0;
        unique case (mem_size)
            2'b00: req_mbe = 4'b0001 << mem_byte_sel;
            2'b01: begin
                req_mbe      = 4'b0011 << mem_byte_sel;
                req_misalign = (mem_byte_sel == 2'b11);
            end
            2'b10: begin
                req_mbe      = 4'b1111;
                req_misalign = (mem_byte_sel != 2'b00);
            end
            default: req_misalign = 1'b1;
        endcase
    end

`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam int unsigned CntW =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CntW-1:0] cnt_q;
    logic            timeout_q;

    // Counter is zero on the first ACCESS cycle, so the strobe lasts exactly TIMEOUT_CYCLES.
    assign timeout_hit = (state_q == StAccess) && !pmem_resp &&
                         (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q != StAccess) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (state_q == StIdle && req) begin
            timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign err_timeout = (state_q == StDone) && timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign err_timeout        = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = req_misalign ? StDone : StAccess;
                end
            end
            StAccess: begin
                if (pmem_resp || timeout_hit) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request capture and read-data return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            mbe_q      <= '0;
            is_write_q <= 1'b0;
            misalign_q <= 1'b0;
            rdata_q    <= '0;
        end else if (state_q == StIdle && req) begin
            addr_q     <= {mem_address[31:2], 2'b00};
            wdata_q    <= req_wdata;
            mbe_q      <= req_mbe;
            is_write_q <= mem_write;
            misalign_q <= req_misalign;
            if (req_misalign) begin
                rdata_q <= '0;
            end
        end else if (state_q == StAccess) begin
            if (pmem_resp) begin
                rdata_q <= pmem_rdata;
            end else if (timeout_hit) begin
                rdata_q <= '0;
            end
        end
    end

    // FSM outputs; strobes follow the state so an async reset drops them at once.
    always_comb begin
        mem_resp     = (state_q == StDone);
        err_misalign = (state_q == StDone) && misalign_q;
        pmem_read    = (state_q == StAccess) && !is_write_q;
        pmem_write   = (state_q == StAccess) && is_write_q;
        mem_rdata    = rdata_q;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        pmem_mbe     = mbe_q;
    end

endmodule
